ps2_kbd_rx: RTL and testbench

- PS/2 keyboard receiver. It samples the external ps2_clk/ps2_data lines, deframes 11-bit frames and checks start, parity and stop bits.
- Valid scan codes are buffered in a small FIFO.
- It is the data source behind the mmio keyboard window: it drives kb_rdata/kb_ready and pops one entry each cycle the mmio read path asserts sig_rd_kb.

---
 rtl/ps2_kbd_rx.sv | 128 ++++++++++++
 tb/tb_ps2_kbd_rx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx -- PS/2 keyboard receiver feeding the mmio keyboard window.
//
// Samples the raw ps2_clk/ps2_data lines, deframes 11-bit frames
// (start, 8 data LSB first, odd parity, stop) and buffers valid scan codes
// in a FIFO_DEPTH-entry FIFO.
//
// Ports:
//   clk        system clock, rising edge
//   clrn       asynchronous active-low reset
//   ps2_clk    raw PS/2 clock (asynchronous to clk)
//   ps2_data   raw PS/2 data  (asynchronous to clk)
//   sig_rd_kb  pop request, one pop per cycle asserted
//   kb_rdata   scan code at FIFO head (0 when empty)
//   kb_ready   FIFO non-empty
//   overflow   sticky: valid frame dropped because FIFO was full
//   frame_err  one-cycle pulse on a bad frame (or on timeout, see below)
//
// Optional macro PS2_TIMEOUT_EN: adds an idle counter that aborts a partial
// frame after TIMEOUT_CYC clk cycles without a ps2_clk falling edge.

module ps2_kbd_rx #(
   parameter int FIFO_DEPTH  = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       sig_rd_kb,
   output logic [7:0] kb_rdata,
   output logic       kb_ready,
   output logic       overflow,
   output logic       frame_err
);

   localparam int            AW      = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]   PTR_ONE = 1;

   logic [2:0]  ps2_clk_sync;
   logic        strobe;
   logic [3:0]  cnt;
   logic [9:0]  buffer;
   logic [7:0]  fifo [FIFO_DEPTH];
   logic [AW:0] wptr, rptr;
   logic        empty, full;
   logic        frame_done, frame_ok;
   logic        push, pop;
   logic        timeout;

   // sync[2] is the oldest sample: 1 then 0 means ps2_clk fell
   assign strobe     = (ps2_clk_sync[2:1] == 2'b10);
   assign frame_done = strobe && (cnt == 4'd10);
   // stop bit is taken live from the line on the final strobe
   assign frame_ok   = ~buffer[0] & (^buffer[9:1]) & ps2_data;

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign pop   = sig_rd_kb & ~empty;
   // a pop in the same cycle frees the slot, so a full FIFO can still accept
   assign push  = frame_done & frame_ok & (~full | pop);

`ifdef PS2_TIMEOUT_EN
   localparam int          IW       = $clog2(TIMEOUT_CYC + 1);
   localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYC);
   localparam logic [IW-1:0] IDLE_ONE = 1;
   logic [IW-1:0] idle;

   // a strobe always wins over the timeout in the same cycle
   assign timeout = (idle == IDLE_MAX) && !strobe && (cnt != 4'd0);

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn)
         idle <= '0;
      else if (strobe || cnt == 4'd0 || timeout)
         idle <= '0;
      else
         idle <= idle + IDLE_ONE;
   end
`else
   assign timeout = 1'b0;
`endif

   // synchroniser and deframer
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         ps2_clk_sync <= 3'b111;
         cnt          <= 4'd0;
         buffer       <= '0;
      end else begin
         ps2_clk_sync <= {ps2_clk_sync[1:0], ps2_clk};
         if (strobe) begin
            if (cnt == 4'd10) begin
               cnt <= 4'd0;
            end else begin
               buffer[cnt] <= ps2_data;
               cnt         <= cnt + 4'd1;
            end
         end else if (timeout) begin
            cnt <= 4'd0;
         end
      end
   end

   // FIFO pointers and status
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         wptr      <= '0;
         rptr      <= '0;
         overflow  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (push) wptr <= wptr + PTR_ONE;
         if (pop)  rptr <= rptr + PTR_ONE;
         if (frame_done && frame_ok && full && !pop)
            overflow <= 1'b1;
         frame_err <= (frame_done & ~frame_ok) | timeout;
      end
   end

   // storage needs no reset: it is only visible through non-empty reads
   always_ff @(posedge clk) begin
      if (push) fifo[wptr[AW-1:0]] <= buffer[8:1];
   end

   assign kb_ready = ~empty;
   assign kb_rdata = empty ? 8'h00 : fifo[rptr[AW-1:0]];

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx (default build, FIFO_DEPTH=8).
// Reference model: a byte queue plus a sticky overflow flag, updated from
// the frame rules (start 0, odd parity, stop 1) and the requested pops.

module tb_ps2_kbd_rx;

   logic       clk = 1'b0;
   logic       clrn = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       sig_rd_kb = 1'b0;
   logic [7:0] kb_rdata;
   logic       kb_ready;
   logic       overflow;
   logic       frame_err;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] mq[$];
   bit         m_ovf = 1'b0;

   always #5 clk = ~clk;

   ps2_kbd_rx #(.FIFO_DEPTH(8), .TIMEOUT_CYC(50000)) dut (
      .clk       (clk),
      .clrn      (clrn),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .sig_rd_kb (sig_rd_kb),
      .kb_rdata  (kb_rdata),
      .kb_ready  (kb_ready),
      .overflow  (overflow),
      .frame_err (frame_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      chk({tag, ".ready"}, {31'd0, kb_ready}, {31'd0, mq.size() != 0});
      chk({tag, ".rdata"}, {24'd0, kb_rdata}, (mq.size() != 0) ? {24'd0, mq[0]} : 32'd0);
      chk({tag, ".ovf"},   {31'd0, overflow}, {31'd0, m_ovf});
   endtask

   // one PS/2 bit: data set while clock high, 6-cycle low phase, high again
   task automatic send_bit(input logic b, input bit last, input bit pop_at_push,
                           inout int errs, inout int lat);
      ps2_data = b;
      repeat (3) begin
         @(negedge clk);
         if (frame_err) errs++;
      end
      ps2_clk = 1'b0;
      for (int k = 0; k < 6; k++) begin
         sig_rd_kb = (last && pop_at_push && k == 2);
         @(negedge clk);
         if (frame_err) errs++;
         if (last && lat < 0 && kb_ready) lat = k + 1;
      end
      sig_rd_kb = 1'b0;
      ps2_clk = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (frame_err) errs++;
      end
   endtask

   // full frame plus model update and checks
   task automatic send_frame(input string tag, input logic [7:0] d,
                             input bit bad_start, input bit bad_par, input bit bad_stop,
                             input bit pop_at_push);
      logic [10:0] bits;
      bit          valid;
      bit          was_empty;
      int          errs;
      int          lat;
      errs = 0;
      lat  = -1;
      was_empty = (mq.size() == 0);
      bits[0]   = bad_start;
      bits[8:1] = d;
      bits[9]   = (~^d) ^ bad_par;
      bits[10]  = ~bad_stop;
      for (int i = 0; i < 11; i++) send_bit(bits[i], i == 10, pop_at_push, errs, lat);
      valid = !bad_start && !bad_par && !bad_stop;
      if (pop_at_push && mq.size() != 0) void'(mq.pop_front());
      if (valid) begin
         if (mq.size() < 8) mq.push_back(d);
         else m_ovf = 1'b1;
      end
      chk({tag, ".err"}, errs, valid ? 0 : 1);
      if (valid && was_empty && !pop_at_push)
         chk({tag, ".lat_ok"}, {31'd0, (lat >= 1 && lat <= 4)}, 32'd1);
      check_state(tag);
   endtask

   task automatic pop_one(input string tag);
      sig_rd_kb = 1'b1;
      @(negedge clk);
      sig_rd_kb = 1'b0;
      if (mq.size() != 0) void'(mq.pop_front());
      check_state(tag);
   endtask

   initial begin
      int quiet_bad;
      // reset state
      #1;
      chk("rst.ready", {31'd0, kb_ready}, 32'd0);
      chk("rst.rdata", {24'd0, kb_rdata}, 32'd0);
      chk("rst.err",   {31'd0, frame_err}, 32'd0);
      repeat (2) @(negedge clk);
      clrn = 1'b1;

      // idle lines: nothing appears for 100 cycles
      quiet_bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (kb_ready || kb_rdata != 8'h00 || overflow || frame_err) quiet_bad++;
      end
      chk("idle.quiet", quiet_bad, 0);

      // single frame then pop
      send_frame("f1c", 8'h1C, 0, 0, 0, 0);
      chk("f1c.data", {24'd0, kb_rdata}, 32'h1C);
      pop_one("f1c.pop");

      // two frames, ordered reads
      send_frame("ff0", 8'hF0, 0, 0, 0, 0);
      send_frame("f1c2", 8'h1C, 0, 0, 0, 0);
      chk("two.head", {24'd0, kb_rdata}, 32'hF0);
      pop_one("two.pop1");
      chk("two.next", {24'd0, kb_rdata}, 32'h1C);
      pop_one("two.pop2");
      pop_one("two.pop_empty");

      // bad parity, bad stop, bad start
      send_frame("badpar",   8'h1C, 0, 1, 0, 0);
      send_frame("badstop",  8'h1C, 0, 0, 1, 0);
      send_frame("badstart", 8'h1C, 1, 0, 0, 0);

      // overflow: nine frames into eight slots
      for (int i = 1; i <= 9; i++) send_frame("fill", 8'(i), 0, 0, 0, 0);
      chk("ovf.set", {31'd0, overflow}, 32'd1);
      for (int i = 1; i <= 8; i++) begin
         chk("ovf.order", {24'd0, kb_rdata}, i);
         pop_one("ovf.pop");
      end

      // reset mid-frame wipes partial frame, FIFO and overflow
      send_frame("pre", 8'h55, 0, 0, 0, 0);
      begin
         int e, l;
         e = 0; l = -1;
         for (int i = 0; i < 5; i++) send_bit(i == 0 ? 1'b0 : 1'b1, 0, 0, e, l);
      end
      clrn = 1'b0;
      #1;
      chk("midrst.ready", {31'd0, kb_ready}, 32'd0);
      chk("midrst.rdata", {24'd0, kb_rdata}, 32'd0);
      chk("midrst.ovf",   {31'd0, overflow}, 32'd0);
      chk("midrst.err",   {31'd0, frame_err}, 32'd0);
      mq.delete();
      m_ovf = 1'b0;
      @(negedge clk);
      clrn = 1'b1;
      repeat (3) @(negedge clk);
      send_frame("postrst", 8'h1C, 0, 0, 0, 0);
      pop_one("postrst.pop");

      // full FIFO with pop in the push cycle: no overflow, entry kept
      for (int i = 0; i < 8; i++) send_frame("refill", 8'($urandom_range(0, 255)), 0, 0, 0, 0);
      send_frame("fullpop", 8'hA7, 0, 0, 0, 1);
      chk("fullpop.ovf", {31'd0, overflow}, 32'd0);
      for (int i = 0; i < 8; i++) pop_one("drain");
      chk("drain.empty", {31'd0, kb_ready}, 32'd0);

      // randomized traffic against the queue model
      for (int n = 0; n < 40; n++) begin
         logic [7:0] d;
         int         r;
         d = 8'($urandom_range(0, 255));
         r = $urandom_range(0, 9);
         send_frame("rnd", d, r == 0, r == 1, r == 2, $urandom_range(0, 3) == 0);
         repeat ($urandom_range(0, 2)) pop_one("rnd.pop");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
